// File: rtl/tile_plot_pkg.sv
// Shared types and helpers for the tile frame plotter.
// State encoding, default colours, width helpers.
package tile_plot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FIELD,
    BORDER,
    SPRITES,
    DONE
  } state_e;

  localparam logic [2:0] DEF_WALL_COLOUR = 3'b111;
  localparam logic [2:0] DEF_BG_COLOUR   = 3'b000;

  // clog2 that never returns 0, so counts of 1 still get a 1-bit bus
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/plot_scan_counter.sv
// 2-D nested scan counter (outer slow, inner fast) with runtime limits.
// Ports: clk, resetn, clear, step, outer_lim/inner_lim in; outer, inner, last out.
module plot_scan_counter
  import tile_plot_pkg::*;
#(
  parameter  int OUTER_MAX = 4,
  parameter  int INNER_MAX = 3,
  localparam int OW = clog2_min1(OUTER_MAX + 1),
  localparam int IW = clog2_min1(INNER_MAX + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clear,
  input  logic          step,
  input  logic [OW-1:0] outer_lim,
  input  logic [IW-1:0] inner_lim,
  output logic [OW-1:0] outer,
  output logic [IW-1:0] inner,
  output logic          last
);

  logic [OW-1:0] outer_q, outer_d;
  logic [IW-1:0] inner_q, inner_d;
  logic          outer_end, inner_end;

  always_comb begin
    outer_end = (outer_q == outer_lim - OW'(1));
    inner_end = (inner_q == inner_lim - IW'(1));
    last      = outer_end && inner_end;
    outer_d   = outer_q;
    inner_d   = inner_q;
    if (clear) begin
      outer_d = '0;
      inner_d = '0;
    end else if (step) begin
      if (inner_end) begin
        inner_d = '0;
        outer_d = outer_end ? '0 : outer_q + OW'(1);
      end else begin
        inner_d = inner_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      outer_q <= '0;
      inner_q <= '0;
    end else begin
      outer_q <= outer_d;
      inner_q <= inner_d;
    end
  end

  assign outer = outer_q;
  assign inner = inner_q;

endmodule

// File: rtl/tile_frame_plotter.sv
// Frame sequencer: map RAM playfield, optional border, sprites -> vga pixel port.
// Ports: start/busy/done, mem_rd/mem_addr/mem_data, spr_*, x/y/colour/plot. Option macro: TILE_PLOT_BORDER_EN.
module tile_frame_plotter
  import tile_plot_pkg::*;
#(
  parameter  int X_W      = 8,
  parameter  int Y_W      = 7,
  parameter  int FIELD_W  = 120,
  parameter  int FIELD_H  = 100,
  parameter  int FIELD_X0 = 20,
  parameter  int FIELD_Y0 = 10,
  parameter  int NUM_SPR  = 2,
  parameter  int SPR_W    = 4,
  parameter  int SPR_H    = 6,
  parameter  int COLOUR_W = 3,
  parameter  logic [COLOUR_W-1:0] WALL_COLOUR = COLOUR_W'(DEF_WALL_COLOUR),
  parameter  logic [COLOUR_W-1:0] BG_COLOUR   = COLOUR_W'(DEF_BG_COLOUR),
  localparam int ADDR_W   = clog2_min1(FIELD_W * FIELD_H)
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         mem_rd,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic                         mem_data,
  input  logic [NUM_SPR-1:0]           spr_en,
  input  logic [NUM_SPR*X_W-1:0]       spr_x,
  input  logic [NUM_SPR*Y_W-1:0]       spr_y,
  input  logic [NUM_SPR*COLOUR_W-1:0]  spr_colour,
  output logic [X_W-1:0]               x,
  output logic [Y_W-1:0]               y,
  output logic [COLOUR_W-1:0]          colour,
  output logic                         plot
);

  localparam int CH_W = clog2_min1(NUM_SPR);
  localparam int OMAX = max3(FIELD_W, SPR_W, 4);
  localparam int IMAX = max3(FIELD_H, FIELD_W + 2, SPR_H);
  localparam int OW   = clog2_min1(OMAX + 1);
  localparam int IW   = clog2_min1(IMAX + 1);

  state_e state_q, state_d;

  logic [NUM_SPR-1:0]          en_q, en_d;
  logic [NUM_SPR*X_W-1:0]      sx_q, sx_d;
  logic [NUM_SPR*Y_W-1:0]      sy_q, sy_d;
  logic [NUM_SPR*COLOUR_W-1:0] sc_q, sc_d;
  logic [CH_W-1:0]             ch_q, ch_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;

  // stage 1: issue register, aligned with the RAM read
  logic                s1_pix_q, s1_pix_d;
  logic                s1_fld_q, s1_fld_d;
  logic [X_W-1:0]      s1_x_q, s1_x_d;
  logic [Y_W-1:0]      s1_y_q, s1_y_d;
  logic [COLOUR_W-1:0] s1_col_q, s1_col_d;
  logic                s1_done_q, s1_done_d;
  logic                mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;

  // stage 2: pixel output register
  logic                plot_q, plot_d;
  logic                fld_q, fld_d;
  logic [X_W-1:0]      x_q, x_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic                done_q, done_d;

  logic          cnt_clear, cnt_step, cnt_last;
  logic [OW-1:0] o_lim, c_out;
  logic [IW-1:0] i_lim, c_in;

  logic            nxt_ok;
  logic [CH_W-1:0] nxt_ch;
  int              base;

  logic [X_W-1:0] spx;
  logic [Y_W-1:0] spy;
  logic           spr_in;

  plot_scan_counter #(
    .OUTER_MAX(OMAX),
    .INNER_MAX(IMAX)
  ) u_scan (
    .clk      (clk),
    .resetn   (resetn),
    .clear    (cnt_clear),
    .step     (cnt_step),
    .outer_lim(o_lim),
    .inner_lim(i_lim),
    .outer    (c_out),
    .inner    (c_in),
    .last     (cnt_last)
  );

  // Border: outer = segment (top, bottom, left, right)
  always_comb begin
    o_lim = OW'(SPR_W);
    i_lim = IW'(SPR_H);
    if (state_q == FIELD) begin
      o_lim = OW'(FIELD_W);
      i_lim = IW'(FIELD_H);
    end else if (state_q == BORDER) begin
      o_lim = OW'(4);
      i_lim = (c_out < OW'(2)) ? IW'(FIELD_W + 2) : IW'(FIELD_H);
    end
  end

  // Next enabled sprite after the current one; -1 searches from channel 0
  always_comb begin
    base   = (state_q == SPRITES) ? int'(ch_q) : -1;
    nxt_ok = 1'b0;
    nxt_ch = '0;
    for (int k = NUM_SPR - 1; k >= 0; k--) begin
      if (en_q[k] && (k > base)) begin
        nxt_ok = 1'b1;
        nxt_ch = CH_W'(k);
      end
    end
  end

  always_comb begin
    spx    = sx_q[int'(ch_q)*X_W +: X_W] + X_W'(c_out);
    spy    = sy_q[int'(ch_q)*Y_W +: Y_W] + Y_W'(c_in);
    spr_in = (int'(spx) >= FIELD_X0) &&
             (int'(spx) <  FIELD_X0 + FIELD_W) &&
             (int'(spy) >= FIELD_Y0) &&
             (int'(spy) <  FIELD_Y0 + FIELD_H);
  end

  always_comb begin
    state_d    = state_q;
    en_d       = en_q;
    sx_d       = sx_q;
    sy_d       = sy_q;
    sc_d       = sc_q;
    ch_d       = ch_q;
    addr_d     = addr_q;
    cnt_clear  = 1'b0;
    cnt_step   = 1'b0;
    s1_pix_d   = 1'b0;
    s1_fld_d   = 1'b0;
    s1_x_d     = s1_x_q;
    s1_y_d     = s1_y_q;
    s1_col_d   = s1_col_q;
    s1_done_d  = 1'b0;
    mem_rd_d   = 1'b0;
    mem_addr_d = '0;
    unique case (state_q)
      IDLE: begin
        cnt_clear = 1'b1;
        addr_d    = '0;
        // hold off while the previous done is still in the pipe
        if (start && !s1_done_q && !done_q) begin
          en_d    = spr_en;
          sx_d    = spr_x;
          sy_d    = spr_y;
          sc_d    = spr_colour;
          state_d = FIELD;
        end
      end
      FIELD: begin
        cnt_step   = 1'b1;
        mem_rd_d   = 1'b1;
        mem_addr_d = addr_q;
        addr_d     = addr_q + ADDR_W'(1);
        s1_pix_d   = 1'b1;
        s1_fld_d   = 1'b1;
        s1_x_d     = X_W'(FIELD_X0 + int'(c_out));
        s1_y_d     = Y_W'(FIELD_Y0 + int'(c_in));
        if (cnt_last) begin
          cnt_clear = 1'b1;
          addr_d    = '0;
`ifdef TILE_PLOT_BORDER_EN
          state_d   = BORDER;
`else
          state_d   = nxt_ok ? SPRITES : DONE;
          ch_d      = nxt_ch;
`endif
        end
      end
`ifdef TILE_PLOT_BORDER_EN
      BORDER: begin
        cnt_step = 1'b1;
        s1_pix_d = 1'b1;
        s1_col_d = WALL_COLOUR;
        unique case (c_out)
          OW'(0): begin
            s1_x_d = X_W'(FIELD_X0 - 1 + int'(c_in));
            s1_y_d = Y_W'(FIELD_Y0 - 1);
          end
          OW'(1): begin
            s1_x_d = X_W'(FIELD_X0 - 1 + int'(c_in));
            s1_y_d = Y_W'(FIELD_Y0 + FIELD_H);
          end
          OW'(2): begin
            s1_x_d = X_W'(FIELD_X0 - 1);
            s1_y_d = Y_W'(FIELD_Y0 + int'(c_in));
          end
          default: begin
            s1_x_d = X_W'(FIELD_X0 + FIELD_W);
            s1_y_d = Y_W'(FIELD_Y0 + int'(c_in));
          end
        endcase
        if (cnt_last) begin
          cnt_clear = 1'b1;
          state_d   = nxt_ok ? SPRITES : DONE;
          ch_d      = nxt_ch;
        end
      end
`endif
      SPRITES: begin
        cnt_step = 1'b1;
        s1_pix_d = spr_in;
        s1_x_d   = spx;
        s1_y_d   = spy;
        s1_col_d = sc_q[int'(ch_q)*COLOUR_W +: COLOUR_W];
        if (cnt_last) begin
          cnt_clear = 1'b1;
          state_d   = nxt_ok ? SPRITES : DONE;
          ch_d      = nxt_ch;
        end
      end
      DONE: begin
        s1_done_d = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    plot_d   = s1_pix_q;
    fld_d    = s1_fld_q;
    x_d      = s1_x_q;
    y_d      = s1_y_q;
    colour_d = s1_col_q;
    done_d   = s1_done_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      en_q       <= '0;
      sx_q       <= '0;
      sy_q       <= '0;
      sc_q       <= '0;
      ch_q       <= '0;
      addr_q     <= '0;
      s1_pix_q   <= 1'b0;
      s1_fld_q   <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_col_q   <= '0;
      s1_done_q  <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      plot_q     <= 1'b0;
      fld_q      <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      colour_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      sc_q       <= sc_d;
      ch_q       <= ch_d;
      addr_q     <= addr_d;
      s1_pix_q   <= s1_pix_d;
      s1_fld_q   <= s1_fld_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
      s1_col_q   <= s1_col_d;
      s1_done_q  <= s1_done_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      plot_q     <= plot_d;
      fld_q      <= fld_d;
      x_q        <= x_d;
      y_q        <= y_d;
      colour_q   <= colour_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != IDLE) || s1_done_q || done_q;
  assign done     = done_q;
  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;
  assign plot     = plot_q;
  assign x        = x_q;
  assign y        = y_q;
  // the map bit arrives from the RAM's own register in the output cycle
  assign colour   = fld_q ? (mem_data ? WALL_COLOUR : BG_COLOUR) : colour_q;

endmodule
